// File: rtl/fsfifo_fwft_pkg.sv
// Shared constants and status helpers for the bridge FIFO family.
package fsfifo_fwft_pkg;

  localparam int FSFIFO_DEF_WIDTH      = 32;
  localparam int FSFIFO_DEF_DEPTH      = 16;
  localparam int FSFIFO_DEF_DEPTH_BITS = $clog2(FSFIFO_DEF_DEPTH);
  localparam int FSFIFO_DEF_FILLED_W   = FSFIFO_DEF_DEPTH_BITS + 1;

  // Status flag bundle shared by the bridge FIFOs. The occupancy count travels
  // alongside it on its own port because its width depends on each instance's DEPTH.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  // All comparisons are unsigned. A threshold above depth can never be reached,
  // so almost-full stays low.
  function automatic fifo_flags_t fifo_flags(input int unsigned filled,
                                             input int unsigned depth,
                                             input int unsigned afull_th,
                                             input int unsigned aempty_th);
    fifo_flags_t f;
    f.full   = (filled == depth);
    f.empty  = (filled == 0);
    f.afull  = (filled >= afull_th);
    f.aempty = (filled <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/fsfifo_fwft_ram.sv
// Simple dual-port storage array: synchronous write, registered read with enable.
// The array itself has no reset; contents are only read after being written.
module fsfifo_ram
  import fsfifo_fwft_pkg::*;
#(
  parameter int WIDTH = FSFIFO_DEF_WIDTH,
  parameter int DEPTH = FSFIFO_DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port; output holds its value while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fsfifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read,
// programmable almost-full/almost-empty, synchronous flush and sticky error flags.
//
// In FWFT mode the head word lives in an output stage (either the RAM read
// register or a bypass register); the memory holds only the words behind it.
// filled_o counts the head too, so capacity is DEPTH in both modes.
module fsfifo_fwft
  import fsfifo_fwft_pkg::*;
#(
  parameter int WIDTH = FSFIFO_DEF_WIDTH,
  parameter int DEPTH = FSFIFO_DEF_DEPTH,
  parameter int FWFT  = 0,
  localparam int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_BITS:0]   filled_o,
  input  logic [DEPTH_BITS:0]   afull_thresh_i,
  input  logic [DEPTH_BITS:0]   aempty_thresh_i,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i
);

  localparam int PTR_W = DEPTH_BITS + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, count_q;
  logic             rd_valid_q;
  logic             src_ram_q;
  logic [WIDTH-1:0] byp_q, ram_q;
  logic             ovf_q, udf_q;
  fifo_flags_t      flags;
  logic             wr_acc, rd_acc, mem_empty, bypass, mem_we, mem_re;

  // Status flags come from registered occupancy and the thresholds only.
  assign flags = fifo_flags(32'(count_q), DEPTH, 32'(afull_thresh_i), 32'(aempty_thresh_i));

  // Accept decisions and routing between memory and the FWFT output stage.
  always_comb begin
    wr_acc    = wr_i && !flags.full && !flush_i;
    rd_acc    = rd_i && !flags.empty && !flush_i;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    bypass    = 1'b0;
    mem_we    = wr_acc;
    mem_re    = rd_acc;
    if (FWFT != 0) begin
      // Head slot is free (empty FIFO) or being vacated with nothing behind it.
      bypass = wr_acc && mem_empty && ((count_q == '0) || rd_acc);
      mem_we = wr_acc && !bypass;
      mem_re = rd_acc && !mem_empty;
    end
  end

  fsfifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[DEPTH_BITS-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q[DEPTH_BITS-1:0]),
    .rdata_o (ram_q)
  );

  // Pointers, occupancy and output-stage source tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      src_ram_q  <= 1'b0;
      byp_q      <= '0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (mem_we) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (mem_re) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_acc && !rd_acc)      count_q <= count_q + PTR_W'(1);
      else if (!wr_acc && rd_acc) count_q <= count_q - PTR_W'(1);
      rd_valid_q <= rd_acc;
      if (bypass) begin
        byp_q     <= wr_data_i;
        src_ram_q <= 1'b0;
      end else if (mem_re) begin
        src_ram_q <= 1'b1;
      end
    end
  end

  // Sticky error flags; a new error wins over a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (!flush_i && wr_i && flags.full)  || (ovf_q && !err_clr_i);
      udf_q <= (!flush_i && rd_i && flags.empty) || (udf_q && !err_clr_i);
    end
  end

  assign rd_data_o   = src_ram_q ? ram_q : byp_q;
  assign rd_valid_o  = (FWFT != 0) ? (count_q != '0) : rd_valid_q;
  assign full_o      = flags.full;
  assign empty_o     = flags.empty;
  assign afull_o     = flags.afull;
  assign aempty_o    = flags.aempty;
  assign filled_o    = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: tb/tb_fsfifo_fwft.sv
// Bench for fsfifo_fwft: a registered-read and an FWFT instance share stimulus
// and are compared against a queue-based reference model every cycle.
module tb_fsfifo_fwft;

  logic       clk = 1'b0;
  logic       reset, flush, wr, rd, err_clr;
  logic [7:0] din;
  logic [2:0] aft, aet;

  logic [7:0] d0_rd, d1_rd;
  logic       d0_rv, d1_rv, d0_full, d1_full, d0_empty, d1_empty;
  logic [2:0] d0_filled, d1_filled;
  logic       d0_afull, d1_afull, d0_aempty, d1_aempty;
  logic       d0_ovf, d1_ovf, d0_udf, d1_udf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_udf, m_rv0;
  logic [7:0] m_rd0;

  always #5 clk = ~clk;

  fsfifo_fwft #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .wr_i(wr), .wr_data_i(din),
    .rd_i(rd), .rd_data_o(d0_rd), .rd_valid_o(d0_rv), .full_o(d0_full),
    .empty_o(d0_empty), .filled_o(d0_filled), .afull_thresh_i(aft),
    .aempty_thresh_i(aet), .afull_o(d0_afull), .aempty_o(d0_aempty),
    .overflow_o(d0_ovf), .underflow_o(d0_udf), .err_clr_i(err_clr)
  );

  fsfifo_fwft #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .wr_i(wr), .wr_data_i(din),
    .rd_i(rd), .rd_data_o(d1_rd), .rd_valid_o(d1_rv), .full_o(d1_full),
    .empty_o(d1_empty), .filled_o(d1_filled), .afull_thresh_i(aft),
    .aempty_thresh_i(aet), .afull_o(d1_afull), .aempty_o(d1_aempty),
    .overflow_o(d1_ovf), .underflow_o(d1_udf), .err_clr_i(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: an ordered list of held words plus sticky flags.
  task automatic model_step(input bit r, input bit f, input bit w, input bit rr,
                            input logic [7:0] d, input bit clr);
    bit is_full, is_empty;
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rv0 = 1'b0; m_rd0 = 8'h00;
    end else if (f) begin
      q.delete();
      m_rv0 = 1'b0;
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      is_full  = (q.size() == 4);
      is_empty = (q.size() == 0);
      m_ovf = (w && is_full)   || (m_ovf && !clr);
      m_udf = (rr && is_empty) || (m_udf && !clr);
      m_rv0 = 1'b0;
      if (rr && !is_empty) begin
        m_rd0 = q.pop_front();
        m_rv0 = 1'b1;
      end
      if (w && !is_full) q.push_back(d);
    end
  endtask

  task automatic model_check();
    int sz;
    sz = q.size();
    check("filled0", 32'(d0_filled), sz);
    check("filled1", 32'(d1_filled), sz);
    check("full0",   32'(d0_full),  32'(sz == 4));
    check("full1",   32'(d1_full),  32'(sz == 4));
    check("empty0",  32'(d0_empty), 32'(sz == 0));
    check("empty1",  32'(d1_empty), 32'(sz == 0));
    check("afull0",  32'(d0_afull),  32'(sz >= int'(aft)));
    check("afull1",  32'(d1_afull),  32'(sz >= int'(aft)));
    check("aempty0", 32'(d0_aempty), 32'(sz <= int'(aet)));
    check("aempty1", 32'(d1_aempty), 32'(sz <= int'(aet)));
    check("ovf0", 32'(d0_ovf), 32'(m_ovf));
    check("ovf1", 32'(d1_ovf), 32'(m_ovf));
    check("udf0", 32'(d0_udf), 32'(m_udf));
    check("udf1", 32'(d1_udf), 32'(m_udf));
    check("rv0",  32'(d0_rv),  32'(m_rv0));
    check("rd0",  32'(d0_rd),  32'(m_rd0));
    check("rv1",  32'(d1_rv),  32'(sz > 0));
    if (sz > 0) check("head1", 32'(d1_rd), 32'(q[0]));
  endtask

  task automatic cycle(input bit r, input bit f, input bit w, input bit rr,
                       input logic [7:0] d, input bit clr);
    reset = r; flush = f; wr = w; rd = rr; din = d; err_clr = clr;
    @(posedge clk);
    model_step(r, f, w, rr, d, clr);
    #1;
    model_check();
  endtask

  task automatic do_rst();                   cycle(1, 0, 0, 0, 8'h00, 0); endtask
  task automatic do_wr(input logic [7:0] d); cycle(0, 0, 1, 0, d,     0); endtask
  task automatic do_rd();                    cycle(0, 0, 0, 1, 8'h00, 0); endtask
  task automatic do_idle();                  cycle(0, 0, 0, 0, 8'h00, 0); endtask

  task automatic reset_checks(input string tag);
    check({tag, "_filled"}, 32'(d0_filled), 0);
    check({tag, "_empty"},  32'(d0_empty),  1);
    check({tag, "_full"},   32'(d0_full),   0);
    check({tag, "_rv0"},    32'(d0_rv),     0);
    check({tag, "_rd0"},    32'(d0_rd),     0);
    check({tag, "_rv1"},    32'(d1_rv),     0);
    check({tag, "_rd1"},    32'(d1_rd),     0);
    check({tag, "_ovf"},    32'(d0_ovf),    0);
    check({tag, "_udf"},    32'(d0_udf),    0);
  endtask

  typedef struct {
    bit         w;
    bit         r;
    logic [7:0] d;
    int         filled;
    bit         full;
    bit         ovf;
    bit         afull;
    bit         aempty;
    bit         rv0;
    logic [7:0] rd0;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    din = 8'h00; aft = 3'd3; aet = 3'd1;

    // Fill/drain with thresholds 3 / 1 on a depth-4 FIFO.
    tbl[0] = '{1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 8'h00};
    tbl[1] = '{1, 0, 8'h22, 2, 0, 0, 0, 0, 0, 8'h00};
    tbl[2] = '{1, 0, 8'h33, 3, 0, 0, 1, 0, 0, 8'h00};
    tbl[3] = '{1, 0, 8'h44, 4, 1, 0, 1, 0, 0, 8'h00};
    tbl[4] = '{1, 0, 8'h55, 4, 1, 1, 1, 0, 0, 8'h00};
    tbl[5] = '{0, 1, 8'h00, 3, 0, 1, 1, 0, 1, 8'h11};
    tbl[6] = '{0, 1, 8'h00, 2, 0, 1, 0, 0, 1, 8'h22};
    tbl[7] = '{0, 1, 8'h00, 1, 0, 1, 0, 1, 1, 8'h33};
    tbl[8] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h44};
    tbl[9] = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h44};

    do_rst();
    do_rst();
    reset_checks("rst");
    check("rst_aempty", 32'(d0_aempty), 1);
    check("rst_afull",  32'(d0_afull),  0);

    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, tbl[i].w, tbl[i].r, tbl[i].d, 0);
      check($sformatf("tbl%0d_filled", i), 32'(d0_filled), tbl[i].filled);
      check($sformatf("tbl%0d_full", i),   32'(d0_full),   32'(tbl[i].full));
      check($sformatf("tbl%0d_ovf", i),    32'(d0_ovf),    32'(tbl[i].ovf));
      check($sformatf("tbl%0d_afull", i),  32'(d0_afull),  32'(tbl[i].afull));
      check($sformatf("tbl%0d_aempty", i), 32'(d0_aempty), 32'(tbl[i].aempty));
      check($sformatf("tbl%0d_rv0", i),    32'(d0_rv),     32'(tbl[i].rv0));
      check($sformatf("tbl%0d_rd0", i),    32'(d0_rd),     32'(tbl[i].rd0));
    end
    check("drain_empty", 32'(d0_empty), 1);

    // FWFT latency: bypass into the head, then pop back to empty.
    do_rst();
    do_wr(8'hA5);
    check("fwft_rv",   32'(d1_rv), 1);
    check("fwft_head", 32'(d1_rd), 32'h0A5);
    do_rd();
    check("fwft_pop_rv",    32'(d1_rv),    0);
    check("fwft_pop_empty", 32'(d1_empty), 1);

    // Simultaneous read/write at two words, then write+read while full.
    do_rst();
    do_wr(8'h01);
    do_wr(8'h02);
    cycle(0, 0, 1, 1, 8'h03, 0);
    check("rw_filled", 32'(d0_filled), 2);
    check("rw_rd0",    32'(d0_rd),     32'h01);
    check("rw_head1",  32'(d1_rd),     32'h02);
    cycle(0, 0, 1, 1, 8'h04, 0);
    check("rw2_rd0",   32'(d0_rd),     32'h02);
    do_wr(8'h05);
    do_wr(8'h06);
    check("rw_full", 32'(d0_full), 1);
    cycle(0, 0, 1, 1, 8'h07, 0);
    check("fullrw_filled", 32'(d0_filled), 3);
    check("fullrw_ovf",    32'(d0_ovf),    1);
    repeat (4) do_rd();

    // Flush with a concurrent write: contents gone, flags and read data kept.
    do_rst();
    do_wr(8'h61); do_wr(8'h62); do_wr(8'h63); do_wr(8'h64);
    do_wr(8'h65);
    do_rd();
    check("prefl_filled", 32'(d0_filled), 3);
    cycle(0, 1, 1, 0, 8'h99, 0);
    check("fl_filled", 32'(d0_filled), 0);
    check("fl_empty",  32'(d0_empty),  1);
    check("fl_rv0",    32'(d0_rv),     0);
    check("fl_rv1",    32'(d1_rv),     0);
    check("fl_ovf",    32'(d0_ovf),    1);
    check("fl_udf",    32'(d0_udf),    0);
    check("fl_rd0",    32'(d0_rd),     32'h61);
    do_idle();
    check("postfl_filled", 32'(d0_filled), 0);

    // Reset in the middle of traffic.
    do_rd();
    check("mid_udf", 32'(d0_udf), 1);
    do_wr(8'h5A); do_wr(8'h5B); do_rd();
    check("mid_rd0", 32'(d0_rd), 32'h5A);
    do_rst();
    reset_checks("midrst");

    // Underflow flag set / clear / set-wins-over-clear.
    do_rd();
    check("udf_set", 32'(d0_udf), 1);
    do_idle();
    check("udf_hold", 32'(d0_udf), 1);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check("udf_clr", 32'(d0_udf), 0);
    cycle(0, 0, 0, 1, 8'h00, 1);
    check("udf_setwins", 32'(d0_udf), 1);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check("udf_clr2", 32'(d0_udf), 0);

    // Pointer wrap: 20 write/read pairs with an incrementing pattern.
    do_rst();
    for (int i = 0; i < 20; i++) begin
      do_wr(8'(8'h30 + i));
      check($sformatf("wrap%0d_head1", i), 32'(d1_rd), 32'(8'(8'h30 + i)));
      do_rd();
      check($sformatf("wrap%0d_rd0", i), 32'(d0_rd), 32'(8'(8'h30 + i)));
    end

    // Random traffic with shifting thresholds and write/read bias.
    do_rst();
    for (int i = 0; i < 1500; i++) begin
      int wp;
      bit r_b, f_b, w_b, rd_b, c_b;
      if (i % 60 == 0) begin
        aft = 3'($urandom_range(0, 7));
        aet = 3'($urandom_range(0, 7));
      end
      wp   = ((i / 100) % 3 == 0) ? 75 : (((i / 100) % 3 == 1) ? 25 : 50);
      r_b  = ($urandom_range(0, 299) == 0);
      f_b  = ($urandom_range(0, 79) == 0);
      w_b  = ($urandom_range(0, 99) < wp);
      rd_b = ($urandom_range(0, 99) < (100 - wp));
      c_b  = ($urandom_range(0, 24) == 0);
      cycle(r_b, f_b, w_b, rd_b, 8'($urandom), c_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
